// File: rtl/elec_config_sequencer.sv
// Electrode configuration sequencer: turns SPI word writes into cache write strobes,
// rotates the configuration cache into the electrode shift chain and counts readback mismatches.
module elec_config_sequencer #(
  parameter int SPI_ADDR_LEN = 6,
  parameter int SPI_DATA_LEN = 16,
  parameter int CHAIN_LEN    = 1024,
  parameter int CNT_W        = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_wr_req,
  input  logic [SPI_ADDR_LEN-1:0] cfg_wr_addr,
  input  logic [SPI_DATA_LEN-1:0] cfg_wr_data,
  output logic                    cfg_wr_ack,
  input  logic                    load_req,
  input  logic                    verify_req,
  input  logic                    cache_bit,
  input  logic                    elec_sdo,
  output logic                    write_cache_en,
  output logic [SPI_ADDR_LEN-1:0] cache_addr,
  output logic [SPI_DATA_LEN-1:0] cache_data,
  output logic [3:0]              cache_state,
  output logic                    elec_sdi,
  output logic                    elec_shift,
  output logic                    elec_latch,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        err_count,
  output logic                    verify_err
);

  // State encoding doubles as the cache state code.
  typedef enum logic [3:0] {
    IDLE   = 4'b0000,
    LOAD   = 4'b0010,
    VERIFY = 4'b0100,
    LATCH  = 4'b0001,
    DONE   = 4'b1000
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] ERR_MAX  = CNT_W'(CHAIN_LEN);

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        bit_cnt_reg, bit_cnt_next;
  logic [CNT_W-1:0]        err_cnt_reg, err_cnt_next;
  logic                    load_pend_reg, load_pend_next;
  logic                    verify_pend_reg, verify_pend_next;
  logic                    op_verify_reg, op_verify_next;
  logic                    verify_err_reg, verify_err_next;
  logic                    wr_stb_reg, wr_stb_next;
  logic [SPI_ADDR_LEN-1:0] addr_reg, addr_next;
  logic [SPI_DATA_LEN-1:0] data_reg, data_next;
  logic                    load_any, verify_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      bit_cnt_reg     <= '0;
      err_cnt_reg     <= '0;
      load_pend_reg   <= 1'b0;
      verify_pend_reg <= 1'b0;
      op_verify_reg   <= 1'b0;
      verify_err_reg  <= 1'b0;
      wr_stb_reg      <= 1'b0;
      addr_reg        <= '0;
      data_reg        <= '0;
    end else begin
      state_reg       <= state_next;
      bit_cnt_reg     <= bit_cnt_next;
      err_cnt_reg     <= err_cnt_next;
      load_pend_reg   <= load_pend_next;
      verify_pend_reg <= verify_pend_next;
      op_verify_reg   <= op_verify_next;
      verify_err_reg  <= verify_err_next;
      wr_stb_reg      <= wr_stb_next;
      addr_reg        <= addr_next;
      data_reg        <= data_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    bit_cnt_next     = bit_cnt_reg;
    err_cnt_next     = err_cnt_reg;
    load_any         = load_req | load_pend_reg;
    verify_any       = verify_req | verify_pend_reg;
    load_pend_next   = load_any;
    verify_pend_next = verify_any;
    op_verify_next   = op_verify_reg;
    verify_err_next  = verify_err_reg;
    wr_stb_next      = 1'b0;
    addr_next        = addr_reg;
    data_next        = data_reg;

    case (state_reg)
      IDLE: begin
        // A held request is acknowledged once; the ack cycle itself blocks re-acceptance.
        if (cfg_wr_req && !wr_stb_reg) begin
          wr_stb_next = 1'b1;
          addr_next   = cfg_wr_addr;
          data_next   = cfg_wr_data;
        end else if ((load_any || verify_any) && !cfg_wr_req && !wr_stb_reg) begin
          bit_cnt_next = '0;
          if (load_any) begin
            state_next     = LOAD;
            load_pend_next = 1'b0;
            op_verify_next = 1'b0;
          end else begin
            state_next       = VERIFY;
            verify_pend_next = 1'b0;
            op_verify_next   = 1'b1;
            err_cnt_next     = '0;
          end
        end
      end
      LOAD: begin
        bit_cnt_next = bit_cnt_reg + 1'b1;
        if (bit_cnt_reg == LAST_BIT) state_next = LATCH;
      end
      VERIFY: begin
        bit_cnt_next = bit_cnt_reg + 1'b1;
        if ((elec_sdo != cache_bit) && (err_cnt_reg != ERR_MAX))
          err_cnt_next = err_cnt_reg + 1'b1;
        if (bit_cnt_reg == LAST_BIT) state_next = DONE;
      end
      LATCH: state_next = DONE;
      DONE: begin
        if (op_verify_reg) verify_err_next = (err_cnt_reg != '0);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign cache_state    = state_reg;
  assign elec_shift     = (state_reg == LOAD) || (state_reg == VERIFY);
  assign elec_sdi       = elec_shift & cache_bit;
  assign elec_latch     = (state_reg == LATCH);
  assign done           = (state_reg == DONE);
  assign busy           = (state_reg != IDLE);
  assign write_cache_en = wr_stb_reg;
  assign cfg_wr_ack     = wr_stb_reg;
  assign cache_addr     = addr_reg;
  assign cache_data     = data_reg;
  assign err_count      = err_cnt_reg;
  assign verify_err     = verify_err_reg;

endmodule

// File: tb/tb_elec_config_sequencer.sv
// Bench for elec_config_sequencer: cache and electrode-chain environment, an operation-timeline
// model compared every cycle, and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_elec_config_sequencer;
  localparam int AW = 6;
  localparam int DW = 16;
  localparam int N  = 1024;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cfg_wr_req = 1'b0;
  logic [AW-1:0] cfg_wr_addr = '0;
  logic [DW-1:0] cfg_wr_data = '0;
  logic          cfg_wr_ack;
  logic          load_req = 1'b0;
  logic          verify_req = 1'b0;
  logic          cache_bit;
  logic          elec_sdo;
  logic          write_cache_en;
  logic [AW-1:0] cache_addr;
  logic [DW-1:0] cache_data;
  logic [3:0]    cache_state;
  logic          elec_sdi, elec_shift, elec_latch, busy, done;
  logic [CW-1:0] err_count;
  logic          verify_err;

  elec_config_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_wr_req(cfg_wr_req), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .cfg_wr_ack(cfg_wr_ack), .load_req(load_req), .verify_req(verify_req),
    .cache_bit(cache_bit), .elec_sdo(elec_sdo), .write_cache_en(write_cache_en),
    .cache_addr(cache_addr), .cache_data(cache_data), .cache_state(cache_state),
    .elec_sdi(elec_sdi), .elec_shift(elec_shift), .elec_latch(elec_latch),
    .busy(busy), .done(done), .err_count(err_count), .verify_err(verify_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment: 1024-bit cache rotating right while in LOAD/VERIFY, and a loopback chain.
  logic [N-1:0] cache_mem = '0;
  logic [N-1:0] chain = '0;
  logic [N-1:0] flip_mask = '0;
  logic         inject = 1'b0;
  assign cache_bit = cache_mem[0];
  assign elec_sdo  = chain[N-1];

  always @(posedge clk) begin
    if (write_cache_en)
      cache_mem[int'(cache_addr)*DW +: DW] <= cache_data;
    else if (cache_state == 4'b0010 || cache_state == 4'b0100)
      cache_mem <= {cache_mem[0], cache_mem[N-1:1]};
    if (elec_shift) chain <= {chain[N-2:0], elec_sdi};
    else if (inject) chain <= chain ^ flip_mask;
  end

  // Model: operation kind (0 none, 1 load, 2 verify) and elapsed cycle within it.
  int            m_kind, m_t, m_err, m_last;
  logic          m_lp, m_vp, m_stb, m_verr, m_la, m_va, m_start, m_acc;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_kind <= 0; m_t <= 0; m_err <= 0; m_lp <= 1'b0; m_vp <= 1'b0;
      m_stb <= 1'b0; m_verr <= 1'b0; m_addr <= '0; m_data <= '0;
    end else begin
      m_last  = (m_kind == 1) ? N + 2 : N + 1;
      m_la    = load_req || m_lp;
      m_va    = verify_req || m_vp;
      m_acc   = (m_kind == 0) && cfg_wr_req && !m_stb;
      m_start = (m_kind == 0) && (m_la || m_va) && !cfg_wr_req && !m_stb;
      m_stb <= m_acc;
      if (m_acc) begin m_addr <= cfg_wr_addr; m_data <= cfg_wr_data; end
      m_lp <= m_la && !(m_start && m_la);
      m_vp <= m_va && !(m_start && !m_la);
      if (m_kind == 2 && m_t <= N && elec_sdo != cache_bit) m_err <= m_err + 1;
      if (m_kind == 2 && m_t == N + 1) m_verr <= (m_err != 0);
      if (m_start) begin
        m_kind <= m_la ? 1 : 2;
        m_t    <= 1;
        if (!m_la) m_err <= 0;
      end else if (m_kind != 0) begin
        if (m_t == m_last) m_kind <= 0;
        else m_t <= m_t + 1;
      end
    end
  end

  // Per-cycle compare against the model.
  logic        e_shift, e_latch, e_done;
  logic [3:0]  e_state;
  logic [22:0] exp_v, act_v;
  always @(negedge clk) begin
    if (rst_n) begin
      e_shift = (m_kind != 0) && (m_t <= N);
      e_latch = (m_kind == 1) && (m_t == N + 1);
      e_done  = ((m_kind == 1) && (m_t == N + 2)) || ((m_kind == 2) && (m_t == N + 1));
      e_state = e_shift ? ((m_kind == 1) ? 4'd2 : 4'd4) : e_latch ? 4'd1 : e_done ? 4'd8 : 4'd0;
      exp_v = {m_stb, m_stb, (m_kind != 0), e_done, e_latch, e_shift, e_shift & cache_bit,
               e_state, m_verr, CW'(m_err)};
      act_v = {write_cache_en, cfg_wr_ack, busy, done, elec_latch, elec_shift, elec_sdi,
               cache_state, verify_err, err_count};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cycle %0d outputs act=%h exp=%h", cyc, act_v, exp_v);
      end
      if (m_stb) begin
        checks++;
        if ({cache_addr, cache_data} !== {m_addr, m_data}) begin
          errors++;
          $display("FAIL cycle %0d write addr/data act=%h exp=%h", cyc,
                   {cache_addr, cache_data}, {m_addr, m_data});
        end
      end
    end
  end

  // Event monitor; per-operation shift statistics restart when shifting begins.
  int   cnt_en = 0, cnt_latch = 0, cnt_done = 0, op_shift = 0, sdi_ones = 0;
  int   sdi_first = -1, sdi_last = -1, shift_idx = 0;
  int   latch_cyc = -1, done_cyc = -1, load_start_cyc = -1;
  logic prev_shift = 1'b0;
  logic [3:0] prev_state = 4'd0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (write_cache_en) cnt_en++;
      if (elec_shift) begin
        if (!prev_shift) begin
          shift_idx = 0; op_shift = 0; sdi_ones = 0; sdi_first = -1; sdi_last = -1;
        end else shift_idx++;
        op_shift++;
        if (elec_sdi) begin
          sdi_ones++;
          if (sdi_first < 0) sdi_first = shift_idx;
          sdi_last = shift_idx;
        end
      end
      prev_shift = elec_shift;
      if (elec_latch) begin cnt_latch++; latch_cyc = cyc; end
      if (done) begin cnt_done++; done_cyc = cyc; end
      if (cache_state == 4'd2 && prev_state != 4'd2) load_start_cyc = cyc;
      prev_state = cache_state;
    end else begin
      prev_shift = 1'b0;
      prev_state = 4'd0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end else
      $display("check %s = %0h", nm, a);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Pulse load/verify for one cycle; ts is the sampling edge in the spec's numbering.
  task automatic pulse_op(input logic l, input logic v, output int ts);
    tick(); load_req = l; verify_req = v;
    tick(); load_req = 1'b0; verify_req = 1'b0;
    ts = cyc - 1;
  endtask

  task automatic wait_done(input int bound);
    int k;
    k = 0;
    @(negedge clk);
    while (!done && k < bound) begin @(negedge clk); k++; end
    checks++;
    if (!done) begin errors++; $display("FAIL wait_done timeout act=0 exp=1"); end
    tick();
  endtask

  // Request is held through the ack cycle, then dropped.
  task automatic cfg_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int ack_at);
    int k;
    k = 0;
    tick(); cfg_wr_req = 1'b1; cfg_wr_addr = a; cfg_wr_data = d;
    tick();
    while (!cfg_wr_ack && k < 3000) begin tick(); k++; end
    checks++;
    if (!cfg_wr_ack) begin errors++; $display("FAIL write ack timeout act=0 exp=1"); end
    ack_at = cyc;
    $display("write addr=%0d data=%h ack at cycle %0d", a, d, ack_at);
    tick(); cfg_wr_req = 1'b0;
  endtask

  function automatic logic [44:0] all_outs();
    return {cfg_wr_ack, write_cache_en, cache_addr, cache_data, cache_state, elec_sdi,
            elec_shift, elec_latch, busy, done, err_count, verify_err};
  endfunction

  initial begin
    int ts, ack_at, base_en, base_latch, base_done;
    logic [N-1:0] snap;
    #1 rst_n = 1'b0;
    #1 chk("reset_outputs_zero", 64'(all_outs()), 64'd0);
    @(negedge clk); @(negedge clk); #2 rst_n = 1'b1;
    repeat (2) tick();

    // Word writes, each acknowledged once despite the held request.
    base_en = cnt_en;
    cfg_write(6'd0, 16'h0001, ack_at);
    chk("en_pulses_w0", cnt_en - base_en, 1);
    cfg_write(6'd63, 16'h8000, ack_at);
    tick();
    chk("en_pulses_w63", cnt_en - base_en, 2);
    chk("cache_word0", cache_mem[15:0], 16'h0001);
    chk("cache_word63", cache_mem[N-1:N-16], 16'h8000);

    // Load from cache.
    snap = cache_mem;
    pulse_op(1'b1, 1'b0, ts);
    wait_done(1100);
    chk("load_sdi_ones", sdi_ones, 2);
    chk("load_sdi_first", sdi_first, 0);
    chk("load_sdi_last", sdi_last, 1023);
    chk("load_latch_offset", latch_cyc - ts, 1025);
    chk("load_done_offset", done_cyc - ts, 1026);
    chk("cache_unchanged", cache_mem == snap, 1);

    // Clean verify.
    pulse_op(1'b0, 1'b1, ts);
    wait_done(1100);
    chk("verify_done_offset", done_cyc - ts, 1025);
    chk("verify_clean_err", err_count, 0);
    chk("verify_clean_flag", verify_err, 0);

    // Three corrupted chain bits.
    flip_mask = '0;
    flip_mask[5] = 1'b1; flip_mask[100] = 1'b1; flip_mask[1000] = 1'b1;
    inject = 1'b1; tick(); inject = 1'b0;
    pulse_op(1'b0, 1'b1, ts);
    wait_done(1100);
    chk("verify_bad_err", err_count, 3);
    chk("verify_bad_flag", verify_err, 1);

    // Load and verify requested together: load first, then verify back to back.
    base_latch = cnt_latch; base_done = cnt_done;
    pulse_op(1'b1, 1'b1, ts);
    wait_done(1100);
    wait_done(1100);
    chk("both_latches", cnt_latch - base_latch, 1);
    chk("both_dones", cnt_done - base_done, 2);
    chk("both_second_done", done_cyc - ts, 2052);
    chk("both_err", err_count, 0);
    chk("both_flag", verify_err, 0);

    // Write raised during LOAD waits for IDLE.
    pulse_op(1'b1, 1'b0, ts);
    repeat (100) tick();
    cfg_write(6'd10, 16'hBEEF, ack_at);
    chk("write_during_load_ack", ack_at - ts, 1028);
    tick();
    chk("cache_word10", cache_mem[175:160], 16'hBEEF);

    // Load request coincident with a write: write first, LOAD two cycles after the strobe.
    tick(); cfg_wr_req = 1'b1; cfg_wr_addr = 6'd20; cfg_wr_data = 16'h1234; load_req = 1'b1;
    tick(); load_req = 1'b0;
    ack_at = cyc;
    chk("coincident_ack", cfg_wr_ack, 1);
    tick(); cfg_wr_req = 1'b0;
    wait_done(1100);
    chk("coincident_load_start", load_start_cyc - ack_at, 2);

    // Reset in the middle of a load.
    pulse_op(1'b1, 1'b0, ts);
    repeat (500) tick();
    base_latch = cnt_latch;
    #2 rst_n = 1'b0;
    #1 chk("midload_reset_zero", 64'(all_outs()), 64'd0);
    @(negedge clk); @(negedge clk); #2 rst_n = 1'b1;
    repeat (3) tick();
    chk("midload_no_latch", cnt_latch - base_latch, 0);
    chk("midload_idle", busy, 0);
    pulse_op(1'b1, 1'b0, ts);
    wait_done(1100);
    chk("postreset_shift_cycles", op_shift, 1024);
    chk("postreset_latch_offset", latch_cyc - ts, 1025);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/elec_config_sequencer.md
# elec_config_sequencer

Sequencer for the 1024-bit electrode configuration cache. It turns SPI-decoded word writes into single-cycle cache writes and drives the cache `state` code to rotate the cache. During a rotation it streams the configuration serially into the electrode shift chain and latches it. It can also run a readback pass that compares the chain output against the cache and counts mismatches.

## Interface
- SPI_ADDR_LEN, 6, cache word address width (64 words)
- SPI_DATA_LEN, 16, cache word width
- CHAIN_LEN, 1024, electrode chain length in bits; equals cache width
- CNT_W, 11, width of bit/error counters (holds CHAIN_LEN)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_wr_req  in  1  word-write request from SPI decoder, level, held until ack
- cfg_wr_addr  in  SPI_ADDR_LEN  word address
- cfg_wr_data  in  SPI_DATA_LEN  word data
- cfg_wr_ack  out  1  one-cycle write acknowledge
- load_req  in  1  one-cycle pulse: load chain from cache
- verify_req  in  1  one-cycle pulse: readback-compare chain
- cache_bit  in  1  cache serial output (cache LSB)
- elec_sdo  in  1  electrode chain serial output
- write_cache_en  out  1  cache write strobe
- cache_addr  out  SPI_ADDR_LEN  registered write address
- cache_data  out  SPI_DATA_LEN  registered write data
- cache_state  out  4  state code to cache; 0010 and 0100 rotate it
- elec_sdi  out  1  chain serial input
- elec_shift  out  1  chain shift enable
- elec_latch  out  1  chain parallel-latch strobe
- busy  out  1  state != IDLE
- done  out  1  one-cycle end-of-operation pulse
- err_count  out  CNT_W  mismatches in last verify
- verify_err  out  1  err_count != 0, registered at DONE

## Operation
- FSM states and cache_state codes: IDLE 0000, LOAD 0010, VERIFY 0100, LATCH 0001, DONE 1000.
- IDLE: accept write when cfg_wr_req && !cfg_wr_ack. Next cycle write_cache_en=1, cfg_wr_ack=1, cache_addr/cache_data = captured values (one cycle).
- Writes are never accepted outside IDLE. The requester holds the request and it is accepted after return to IDLE.
- load_req/verify_req set load_pend/verify_pend flags in any state; requests already pending are not duplicated.
- IDLE start condition: (load_req|load_pend|verify_req|verify_pend) && !cfg_wr_req && !write_cache_en. Load has priority over verify. The taken flag clears on the start edge.
- LOAD: bit_cnt 0..CHAIN_LEN-1. Each cycle: elec_shift=1, elec_sdi=cache_bit (combinational), cache rotates one bit. After CHAIN_LEN cycles the cache is back in its original phase. At bit_cnt==CHAIN_LEN-1 -> LATCH.
- LATCH: elec_latch=1 for one cycle -> DONE.
- VERIFY: err_count cleared on entry. Shift exactly as LOAD (re-writes identical data). Each cycle, if elec_sdo != cache_bit then err_count+1. At bit_cnt==CHAIN_LEN-1 -> DONE (no latch).
- DONE: done=1. verify_err updated only if the operation was VERIFY -> IDLE.
- elec_sdi=0 and elec_shift=0 outside LOAD/VERIFY.

## Timing
- Reset: state IDLE, all outputs 0, pend flags 0, counters 0.
- Write latency: req sampled at edge N -> write_cache_en/ack high in cycle N+1 only.
- Load started by sample at edge T: LOAD cycles T+1..T+CHAIN_LEN, LATCH T+CHAIN_LEN+1, DONE T+CHAIN_LEN+2, IDLE after.
- Verify: same timing with no LATCH; DONE at T+CHAIN_LEN+1.
- write_cache_en is never high while cache_state is 0010/0100.
- err_count max CHAIN_LEN, no wrap.
- Reset mid-operation: immediate return to IDLE. Pend flags and counters clear. No latch pulse.

## Test plan
- Write addr 0 = 0x0001, addr 63 = 0x8000 -> one ack each, write_cache_en one cycle with matching addr/data. Req held over ack cycle causes no double write.
- load_req -> elec_sdi=1 at LOAD cycles 0 and 1023, 0 elsewhere. elec_latch at +1025, done at +1026. Cache contents unchanged afterward.
- Chain loopback model (1024-bit shift register), load then verify -> err_count=0, verify_err=0. Inject 3 flipped chain bits -> err_count=3, verify_err=1.
- load_req and verify_req in same cycle -> LOAD+LATCH+DONE, then VERIFY+DONE back to back.
- cfg_wr_req raised during LOAD -> no ack until IDLE, then ack. load_req coincident with pending write -> write first, LOAD starts after write_cache_en drops.
- rst_n low at LOAD cycle 500 -> all outputs 0 asynchronously, no elec_latch, next load_req runs full 1024 cycles.
